rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
// - Shares the single register-file write port (write-enable, A3, WD) among NREQ writeback sources,
//   e.g. ALU, load unit, multiply/divide unit.
// - Keeps a per-register busy scoreboard so that decode stalls on RAW and WAW hazards until the
//   pending write has retired.
// - Sits between execute/memory writeback and the register file; decode drives the issue/check side.
// PARAMETERS
// - NREQ  3   number of writeback requesters (2..8)
// - AW    5   register address width (2**AW registers)
// - DW    32  data width
// PORTS
// - clk        in   1        clock, rising edge
// - rst        in   1        asynchronous, active-low reset
// - req_valid  in   NREQ     requester i has a write pending
// - req_addr   in   NREQ*AW  destination of requester i, slice [i*AW +: AW]
// - req_data   in   NREQ*DW  write data of requester i, slice [i*DW +: DW]
// - req_ready  out  NREQ     one-hot grant; the transfer happens when valid & ready
// - rf_wr      out  1        register-file write enable (registered)
// - rf_a3      out  AW       register-file write address (registered)
// - rf_wd      out  DW       register-file write data (registered)
// - iss_valid  in   1        decode issues an instruction that will write iss_rd
// - iss_rd     in   AW       destination of the issuing instruction
// - iss_ready  out  1        issue accepted this cycle
// - chk_a1     in   AW       source operand 1 of the instruction in decode
// - chk_a2     in   AW       source operand 2 of the instruction in decode
// - stall      out  1        decode must hold (RAW or WAW hazard)
// - busy_vec   out  2**AW    scoreboard, bit r = write to r outstanding
// BEHAVIOUR
// - Reset (rst=0, async): rf_wr=0, rf_a3=0, rf_wd=0, busy_vec=0, rr_ptr=0.
//   - Combinational outputs settle from these values.
//   - Reset mid-transfer drops the in-flight write; no write reaches the register file.
// - Arbitration (combinational): round-robin starting at rr_ptr.
//   - Grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
//   - req_ready = one-hot of that i, or 0 if no request is valid.
//   - A requester must hold valid, addr and data stable until it is granted.
// - rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds.
// - Output stage: a single register with latency 1.
//   - A grant in cycle t gives rf_wr=1, rf_a3=addr_i, rf_wd=data_i in cycle t+1.
//   - With no grant in t, rf_wr=0 in t+1 and rf_a3/rf_wd hold their values.
//   - There is no backpressure from the register file; one write can be granted every cycle.
// - Address 0: the request is still granted (it is consumed), but rf_wr stays 0 for it and no
//   busy bit changes.
// - Scoreboard:
//   - busy[iss_rd] <= 1 on iss_valid & iss_ready & iss_rd!=0.
//   - busy[rf_a3] <= 0 on the clock edge that ends a cycle with rf_wr=1.
//   - The register file captures data on that same edge, so a read in the next cycle sees the
//     new value.
// - iss_ready = !busy[iss_rd]. A WAW hazard blocks the issue; at most one write per register
//   is outstanding.
// - Same-cycle issue and retire of one register: busy is still 1, so iss_ready=0 and no conflict
//   can arise.
// - stall = (chk_a1!=0 & busy[chk_a1]) | (chk_a2!=0 & busy[chk_a2]) | (iss_valid & !iss_ready).
// - busy[0] is always 0. A write request to a register that is not busy is legal (untracked
//   write); it is performed and leaves busy unchanged.
// - No bypass/forwarding: a stall lasts until the cycle after rf_wr for that register.
// STRUCTURE
// - Shared package: AW, DW, NREQ defaults; REG_ZERO=0.
// - Sub-module rr_arbiter (NREQ): valid vector in, rr_ptr in, one-hot grant and grant index out.
// - Top module: output register, rr_ptr register, scoreboard, hazard logic.
// TESTING
// - Reset mid-operation: assert rst=0 while busy_vec=0x0000_0006 and rf_wr=1.
//   -> All outputs 0 immediately; no write occurs.
// - Single requester: req0 writes r5=0x1234 in cycle t.
//   -> req_ready=001 in t; rf_wr=1, rf_a3=5, rf_wd=0x1234 in t+1.
// - Round-robin: all three valid for 4 cycles starting at rr_ptr=0.
//   -> grants 001, 010, 100, 001; rf_a3 follows the same order one cycle later.
// - RAW stall: issue rd=7; next cycle chk_a1=7 -> stall=1.
//   - req1 then writes r7. stall stays 1 through the rf_wr cycle and is 0 the cycle after.
// - WAW stall and the zero register:
//   - iss_rd=3 while busy[3]=1 -> iss_ready=0, stall=1.
//   - iss_rd=0 -> accepted, busy_vec unchanged.
//   - req2 with addr 0 -> granted, rf_wr stays 0.
// - Back-to-back writes: req0 and req1 both target r9 in consecutive cycles.
//   -> two rf_wr cycles, last value 0xBEEF wins; busy[9] clears after the first write.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and helpers for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int REG_ZERO = 0;

  // Round-robin successor of a granted index.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester
// found when scanning from ptr upwards, modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   gidx,
  output logic            gvalid
);

  // Scan from the farthest position back to ptr so the nearest valid one wins.
  always_comb begin
    int idx;
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        gvalid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and
// tracks outstanding writes per register so decode can stall on RAW/WAW.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_wr,
  output logic [AW-1:0]        rf_a3,
  output logic [DW-1:0]        rf_wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_ready,
  input  logic [AW-1:0]        chk_a1,
  input  logic [AW-1:0]        chk_a2,
  output logic                 stall,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int PW = $clog2(NREQ);
  localparam int NR = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NR-1:0]   busy_reg;
  logic [NR-1:0]   busy_next;

  // Unpack the flattened request buses into per-requester fields.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
    assign data_arr[gi] = req_data[gi*DW +: DW];
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .valid  (req_valid),
    .ptr    (rr_ptr_reg),
    .grant  (req_ready),
    .gidx   (gnt_idx),
    .gvalid (gnt_any)
  );

  assign sel_addr = addr_arr[gnt_idx];
  assign sel_data = data_arr[gnt_idx];

  // Round-robin pointer moves just past the last granted requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr_reg <= '0;
    else if (gnt_any)
      rr_ptr_reg <= PW'(next_ptr(int'(gnt_idx), NREQ));
  end

  // Output register: one write per grant, writes to r0 are consumed silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else begin
      rf_wr <= gnt_any && (sel_addr != ZERO_ADDR);
      if (gnt_any) begin
        rf_a3 <= sel_addr;
        rf_wd <= sel_data;
      end
    end
  end

  // Scoreboard next state: retire clears, then a new issue sets (issue is younger).
  always_comb begin
    busy_next = busy_reg;
    if (rf_wr)
      busy_next[rf_a3] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != ZERO_ADDR))
      busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  // Hazard detection: WAW blocks issue, RAW on either source stalls decode.
  always_comb begin
    iss_ready = !busy_reg[iss_rd];
    stall     = ((chk_a1 != ZERO_ADDR) && busy_reg[chk_a1]) ||
                ((chk_a2 != ZERO_ADDR) && busy_reg[chk_a2]) ||
                (iss_valid && !iss_ready);
  end

  assign busy_vec = busy_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_wr;
  logic [AW-1:0]      rf_a3;
  logic [DW-1:0]      rf_wd;
  logic               iss_valid;
  logic [AW-1:0]      iss_rd;
  logic               iss_ready;
  logic [AW-1:0]      chk_a1;
  logic [AW-1:0]      chk_a2;
  logic               stall;
  logic [31:0]        busy_vec;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_wr     (rf_wr),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .stall     (stall),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_a1 = '0; chk_a2 = '0;
    tick(); tick();
    check("rst_wr", rf_wr, 0);
    check("rst_a3", rf_a3, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_ready", req_ready, 0);
    check("rst_stall", stall, 0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Round-robin from rr_ptr=0 with all three requesters valid.
    set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hA2); set_req(2, 5'd3, 32'hA3);
    req_valid = 3'b111; #1;
    check("rr_g0", req_ready, 3'b001);
    tick(); #1;
    check("rr_g1", req_ready, 3'b010);
    check("rr_a3_0", rf_a3, 1);
    check("rr_wd_0", rf_wd, 32'hA1);
    tick(); #1;
    check("rr_g2", req_ready, 3'b100);
    check("rr_a3_1", rf_a3, 2);
    tick(); #1;
    check("rr_g3", req_ready, 3'b001);
    check("rr_a3_2", rf_a3, 3);
    tick(); req_valid = '0; #1;
    check("rr_a3_3", rf_a3, 1);
    check("rr_wr_3", rf_wr, 1);
    tick();
    check("rr_idle_wr", rf_wr, 0);

    // Single requester: req0 writes r5 (rr_ptr is 1 here, scan wraps to 0).
    set_req(0, 5'd5, 32'h1234); req_valid = 3'b001; #1;
    check("single_ready", req_ready, 3'b001);
    tick(); req_valid = '0; #1;
    check("single_wr", rf_wr, 1);
    check("single_a3", rf_a3, 5);
    check("single_wd", rf_wd, 32'h1234);
    tick();
    check("single_wr_off", rf_wr, 0);
    check("single_a3_hold", rf_a3, 5);
    check("single_wd_hold", rf_wd, 32'h1234);

    // RAW stall: issue rd=7, then read r7, then req1 retires r7.
    iss_valid = 1'b1; iss_rd = 5'd7; #1;
    check("raw_iss_ready", iss_ready, 1);
    tick(); iss_valid = 1'b0; chk_a1 = 5'd7; #1;
    check("raw_busy", busy_vec, 32'h80);
    check("raw_stall0", stall, 1);
    set_req(1, 5'd7, 32'h77); req_valid = 3'b010; #1;
    check("raw_grant", req_ready, 3'b010);
    check("raw_stall1", stall, 1);
    tick(); req_valid = '0; #1;
    check("raw_wr", rf_wr, 1);
    check("raw_a3", rf_a3, 7);
    check("raw_stall_wrcycle", stall, 1);
    tick();
    check("raw_stall_clear", stall, 0);
    check("raw_busy_clear", busy_vec, 0);
    chk_a1 = '0;

    // WAW on r3 and the zero register.
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick(); #1;
    check("waw_busy", busy_vec, 32'h8);
    check("waw_iss_ready", iss_ready, 0);
    check("waw_stall", stall, 1);
    tick();
    check("waw_busy_hold", busy_vec, 32'h8);
    iss_rd = 5'd0; #1;
    check("zero_iss_ready", iss_ready, 1);
    check("zero_stall", stall, 0);
    tick(); iss_valid = 1'b0;
    check("zero_busy", busy_vec, 32'h8);
    set_req(2, 5'd0, 32'hDEAD); req_valid = 3'b100; #1;
    check("zero_grant", req_ready, 3'b100);
    tick(); req_valid = '0; #1;
    check("zero_wr", rf_wr, 0);
    check("zero_busy2", busy_vec, 32'h8);

    // Back-to-back writes to r9 from req0 then req1.
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); iss_valid = 1'b0;
    set_req(0, 5'd9, 32'hAAAA); req_valid = 3'b001; #1;
    check("b2b_g0", req_ready, 3'b001);
    tick();
    req_valid = 3'b010; set_req(1, 5'd9, 32'hBEEF); #1;
    check("b2b_g1", req_ready, 3'b010);
    check("b2b_wr0", rf_wr, 1);
    check("b2b_wd0", rf_wd, 32'hAAAA);
    check("b2b_busy0", busy_vec, 32'h208);
    tick(); req_valid = '0; #1;
    check("b2b_wr1", rf_wr, 1);
    check("b2b_a31", rf_a3, 9);
    check("b2b_wd1", rf_wd, 32'hBEEF);
    check("b2b_busy1", busy_vec, 32'h8);
    tick();
    check("b2b_idle", rf_wr, 0);
    check("b2b_last", rf_wd, 32'hBEEF);

    // Reset mid-operation with busy=0x6 and a write on the output.
    rst = 1'b0; tick(); rst = 1'b1;
    iss_valid = 1'b1; iss_rd = 5'd1;
    tick(); iss_rd = 5'd2;
    tick(); iss_valid = 1'b0;
    check("mid_busy", busy_vec, 32'h6);
    set_req(0, 5'd1, 32'h55); req_valid = 3'b001;
    tick(); req_valid = '0; #1;
    check("mid_wr_pre", rf_wr, 1);
    check("mid_busy_pre", busy_vec, 32'h6);
    rst = 1'b0; #1;
    check("mid_wr", rf_wr, 0);
    check("mid_a3", rf_a3, 0);
    check("mid_wd", rf_wd, 0);
    check("mid_busy_rst", busy_vec, 0);
    check("mid_stall", stall, 0);
    tick();
    check("mid_wr_held", rf_wr, 0);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
